// File: rtl/pool_window_feeder_pkg.sv
// Shared constants and types for the max-pool window feeder.
package pkg_parameters;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_EMIT = 2'd1,
        ST_COOL = 2'd2
    } feeder_state_e;

    localparam logic [3:0] SLOT_ELEM_FIRST = 4'd0;
    localparam logic [3:0] SLOT_ELEM_LAST  = 4'd6;
    localparam logic [3:0] SLOT_DONE       = 4'd8;
    localparam logic [3:0] SLOT_LAST       = 4'd10;
endpackage

// File: rtl/pool_window_feeder_if.sv
// Pixel-in / element-out handshake bundle between upstream, feeder and pooler.
interface pool_window_feeder_if #(parameter int DATA_W = 8);
    logic              in_valid_i;
    logic [DATA_W-1:0] in_data_i;
    logic              in_ready_o;
    logic              mx_valid_o;
    logic [DATA_W-1:0] mx_data_o;
    logic              mx_done_o;

    modport master (
        output in_valid_i, in_data_i,
        input  in_ready_o, mx_valid_o, mx_data_o, mx_done_o
    );
    modport slave (
        input  in_valid_i, in_data_i,
        output in_ready_o, mx_valid_o, mx_data_o, mx_done_o
    );
endinterface

// File: rtl/pool_window_feeder_line_buffer.sv
// One-row pixel store: single synchronous write, two combinational reads.
module pool_line_buffer #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int CW     = 3
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [CW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [CW-1:0]     i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [CW-1:0]     i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b
);
    logic [DATA_W-1:0] r_mem [IMG_W];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];
endmodule

// File: rtl/pool_window_feeder.sv
// Buffers one row and replays each 2x2 window as paced element pulses plus a done pulse.
// Optional frame_done_o port is enabled by defining POOL_FEEDER_FRAME_DONE_EN.
module pool_window_feeder
    import pkg_parameters::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input logic clk_i,
    input logic rst_ni,
    pool_window_feeder_if.slave bus
`ifdef POOL_FEEDER_FRAME_DONE_EN
    ,
    output logic frame_done_o
`endif
);
    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;

    feeder_state_e     r_state;
    logic [3:0]        r_slot;
    logic [CW-1:0]     r_col, r_win_col;
    logic [RW-1:0]     r_row;
    logic              r_in_ready, r_mx_valid, r_mx_done;
    logic [DATA_W-1:0] r_mx_data, r_hold, r_cur;

    logic              w_accept, w_br, w_col_last, w_row_last;
    logic [CW-1:0]     w_rd_col, w_rd_prev;
    logic [DATA_W-1:0] w_lb_a, w_lb_b;

    assign w_accept   = bus.in_valid_i && r_in_ready;
    assign w_br       = w_accept && r_row[0] && r_col[0];
    assign w_col_last = (r_col == CW'(IMG_W - 1));
    assign w_row_last = (r_row == RW'(IMG_H - 1));
    // The column counter has already moved on during EMIT, so reads use the latched window column.
    assign w_rd_col   = (r_state == ST_FILL) ? r_col : r_win_col;
    assign w_rd_prev  = w_rd_col - CW'(1);

    pool_line_buffer #(.DATA_W(DATA_W), .IMG_W(IMG_W), .CW(CW)) u_linebuf (
        .i_clk     (clk_i),
        .i_we      (w_accept && !r_row[0]),
        .i_waddr   (r_col),
        .i_wdata   (bus.in_data_i),
        .i_raddr_a (w_rd_prev),
        .o_rdata_a (w_lb_a),
        .i_raddr_b (w_rd_col),
        .o_rdata_b (w_lb_b)
    );

    always_ff @(posedge clk_i) begin
        if (w_accept && r_row[0]) begin
            if (r_col[0]) r_cur  <= bus.in_data_i;
            else          r_hold <= bus.in_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= ST_FILL;
            r_slot     <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_win_col  <= '0;
            r_in_ready <= 1'b0;
            r_mx_valid <= 1'b0;
            r_mx_done  <= 1'b0;
            r_mx_data  <= '0;
        end else begin
            r_mx_valid <= 1'b0;
            r_mx_done  <= 1'b0;
            case (r_state)
                ST_FILL: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        if (w_col_last) begin
                            r_col <= '0;
                            r_row <= w_row_last ? '0 : r_row + RW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                    if (w_br) begin
                        r_state    <= ST_EMIT;
                        r_slot     <= SLOT_ELEM_FIRST;
                        r_win_col  <= r_col;
                        r_in_ready <= 1'b0;
                        r_mx_valid <= 1'b1;
                        r_mx_data  <= w_lb_a;
                    end
                end
                ST_EMIT: begin
                    // Outputs are registered, so each case prepares the following slot.
                    r_slot <= r_slot + 4'd1;
                    case (r_slot)
                        4'd1: begin r_mx_valid <= 1'b1; r_mx_data <= w_lb_b; end
                        4'd3: begin r_mx_valid <= 1'b1; r_mx_data <= r_hold; end
                        4'd5: begin r_mx_valid <= 1'b1; r_mx_data <= r_cur;  end
                        4'd7: r_mx_done <= 1'b1;
                        default: ;
                    endcase
                    if (r_slot == SLOT_DONE) r_state <= ST_COOL;
                end
                ST_COOL: begin
                    r_slot <= r_slot + 4'd1;
                    if (r_slot == SLOT_LAST) begin
                        r_state    <= ST_FILL;
                        r_slot     <= '0;
                        r_in_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_FILL;
            endcase
        end
    end

`ifdef POOL_FEEDER_FRAME_DONE_EN
    logic r_last_win, r_frame_done;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_last_win   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_br) r_last_win <= w_row_last && w_col_last;
            r_frame_done <= (r_state == ST_EMIT) && (r_slot == SLOT_DONE - 4'd1) && r_last_win;
        end
    end

    assign frame_done_o = r_frame_done;
`endif

    assign bus.in_ready_o = r_in_ready;
    assign bus.mx_valid_o = r_mx_valid;
    assign bus.mx_data_o  = r_mx_data;
    assign bus.mx_done_o  = r_mx_done;
endmodule

// File: doc/pool_window_feeder.md
# pool_window_feeder

Upstream stage of the signed max-pooling unit. Accepts a raster-scan feature map one pixel per handshake, buffers one row, and replays each non-overlapping 2x2 window to the pooler as four single-cycle element pulses followed by a window-done pulse. The pulse pacing matches the pooler's per-element and per-window FSM turnaround. The pooler's `exe_mx_valid_o`/`exe_mx_data_o` pass straight to the next layer.

## Interface
- `DATA_W`, 8: pixel width, signed two's complement (matches pooler `MX_RESOLUTION`).
- `IMG_W`, 8: feature-map width in pixels; must be even and at least 2.
- `IMG_H`, 8: feature-map height in rows; must be even and at least 2.
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `in_valid_i` in 1: upstream pixel valid.
- `in_data_i` in `DATA_W`: upstream pixel, raster order (row-major, column 0 first).
- `in_ready_o` out 1: feeder accepts a pixel when `in_valid_i && in_ready_o`.
- `mx_valid_o` out 1: element pulse; connects to pooler `load_mx_valid_i`.
- `mx_data_o` out `DATA_W`: element value; connects to `load_mx_data_i`.
- `mx_done_o` out 1: window-complete pulse; connects to `exe_mx_ready_i`.
- `frame_done_o` out 1: present only with `POOL_FEEDER_FRAME_DONE_EN`.

## Operation
- Counters: `col` (0..IMG_W-1), `row` (0..IMG_H-1), `slot` (0..10). The row and column counters advance only on an input handshake.
- States:
  - ST_FILL: `in_ready_o`=1.
    - On each accept in an even row, write the pixel to `linebuf[col]`.
    - In an odd row at an even column, capture the pixel in `hold`.
    - In an odd row at an odd column, capture the pixel in `cur` and go to ST_EMIT with `slot`=0.
  - ST_EMIT: `in_ready_o`=0; `slot` increments each cycle.
    - Slots 0, 2, 4 and 6 assert `mx_valid_o` with `linebuf[col-1]`, `linebuf[col]`, `hold` and `cur` respectively. Here `col` is the column of the accepted bottom-right pixel.
    - Slots 1, 3, 5 and 7 are idle.
    - Slot 8 asserts `mx_done_o` with `mx_valid_o` low.
    - Then go to ST_COOL.
  - ST_COOL: slots 9 and 10, all pulses low, `in_ready_o`=0. Then go to ST_FILL.
- `mx_data_o` is registered. It holds its last value between pulses, because the pooler samples data one cycle after valid.
- `mx_valid_o` and `mx_done_o` are never high in the same cycle.
- Data passes through bit-exact; there is no arithmetic on pixel values.
- Wrap-around: after the accept at `row`=IMG_H-1 and `col`=IMG_W-1, both counters return to 0. The next frame starts with no dead cycle beyond ST_EMIT and ST_COOL.
- The line buffer is not cleared between frames; each even row overwrites it fully.

## Timing
- Reset values: `in_ready_o`=0, `mx_valid_o`=0, `mx_data_o`=0, `mx_done_o`=0, `frame_done_o`=0. State is ST_FILL, all counters are 0.
- `in_ready_o` rises in the first cycle after `rst_ni` deasserts. This guarantees the pooler has left its IDLE state before the first pulse.
- The bottom-right pixel is accepted in cycle a:
  - element pulses in cycles a+1, a+3, a+5 and a+7;
  - `mx_done_o` in cycle a+9;
  - `in_ready_o` high again in cycle a+12.
- Sustained input rate: one pixel per cycle in even rows and at even columns of odd rows. There are 11 stall cycles per window.
- Reset mid-window, in any state: the window is abandoned and all outputs take their reset values in the next cycle. The pooler shares `rst_ni`.
- `in_valid_i` low at any time only delays progress; counters hold.

## Configuration
- `POOL_FEEDER_FRAME_DONE_EN`:
  - Defined: adds port `frame_done_o`, a one-cycle pulse coincident with `mx_done_o` of the last window of a frame (row IMG_H-1, column IMG_W-1).
  - Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- `pkg_parameters` holds:
  - the `DATA_W` default constant;
  - the feeder state enum typedef (ST_FILL, ST_EMIT, ST_COOL);
  - slot constants: the first and last element slots, `SLOT_DONE`=8, `SLOT_LAST`=10.
- One sub-module, `pool_line_buffer`: `IMG_W` x `DATA_W` register array with one synchronous write port and two combinational read ports (`col-1`, `col`). It has no reset.

## Test plan
- 4x2 map, row0 = 1,2,3,4 and row1 = 5,6,7,8, streamed with `in_valid_i` held high:
  - first window emits 1,2,5,6 on alternate cycles, then `mx_done_o`;
  - second window emits 3,4,7,8;
  - attached pooler outputs 6 then 8.
- Signed values: window -128 (8'h80), -1, 0, -5. Elements pass bit-exact and the pooler outputs 0.
- Random `in_valid_i` gaps over 8x4 frames. Check the element order, the pulse spacing of two cycles, and done at +8 from the first pulse.
- Assert `rst_ni` in slot 4 of a window:
  - outputs reach reset values next cycle;
  - after release, a fresh frame of all 7s yields four pooled outputs of 7 (8x2 map).
- Two back-to-back 4x4 frames of distinct values:
  - counters wrap;
  - the second frame's first window uses only second-frame pixels.
- With `POOL_FEEDER_FRAME_DONE_EN`, a 4x4 map: `frame_done_o` pulses exactly once per frame, coincident with the fourth `mx_done_o`.
